// File: rtl/outpass_config_sequencer.sv
// outpass_config_sequencer: byte-framed shadow/commit controller for output-pass BEL bypass selects.
// Optional readback of active selects via opcode 11 when OUTPASS_CFG_READBACK_EN is defined.
module outpass_config_sequencer #(
  parameter int NUM_BELS     = 4,
  parameter int BITS_PER_BEL = 4
) (
  input  logic                             UserCLK,
  input  logic                             resetn,
  input  logic                             frame_valid,
  output logic                             frame_ready,
  input  logic [7:0]                       frame_data,
  input  logic                             frame_last,
  output logic [NUM_BELS*BITS_PER_BEL-1:0] ConfigBits,
  output logic                             cfg_update,
  output logic                             err
`ifdef OUTPASS_CFG_READBACK_EN
  ,
  output logic                             rd_valid,
  output logic [BITS_PER_BEL-1:0]          rd_data
`endif
);
  localparam int W = NUM_BELS * BITS_PER_BEL;
  typedef enum logic [1:0] {IDLE, DATA, COMMIT, DRAIN} state_t;
  state_t state, nxt;
  logic [W-1:0] shadow;
  logic [5:0] idx;
  logic [1:0] op;
  logic acc, in_rng, ok, set_err, do_wr, do_clear;
  assign acc    = frame_valid & frame_ready;
  assign op     = frame_data[7:6];
  assign in_rng = {1'b0, frame_data[5:0]} < 7'(NUM_BELS);
`ifdef OUTPASS_CFG_READBACK_EN
  logic do_rd;
  logic [BITS_PER_BEL-1:0] sel;
  assign ok    = op == 2'b00 ? !frame_last && in_rng : op == 2'b11 ? frame_last && in_rng : frame_last;
  assign do_rd = state == IDLE && acc && ok && op == 2'b11;
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_BELS; k++)
      if (frame_data[5:0] == 6'(k)) sel = ConfigBits[k*BITS_PER_BEL +: BITS_PER_BEL];
  end
`else
  assign ok = op == 2'b00 ? !frame_last && in_rng : op == 2'b11 ? 1'b0 : frame_last;
`endif
  always_comb begin
    nxt      = state;
    set_err  = 1'b0;
    do_wr    = 1'b0;
    do_clear = 1'b0;
    case (state)
      IDLE: if (acc) begin
        set_err  = !ok;
        do_clear = ok && op == 2'b10;
        nxt      = !ok ? (frame_last ? IDLE : DRAIN) : op == 2'b00 ? DATA : op == 2'b01 ? COMMIT : IDLE;
      end
      DATA: if (acc) begin
        do_wr   = 1'b1;
        set_err = !frame_last;
        nxt     = frame_last ? IDLE : DRAIN;
      end
      COMMIT: nxt = IDLE;
      default: if (acc && frame_last) nxt = IDLE;
    endcase
  end
  always_ff @(posedge UserCLK)
    if (!resetn) state <= IDLE;
    else state <= nxt;
  // Ready is registered from the next state so the COMMIT cycle shows as a bubble.
  always_ff @(posedge UserCLK)
    if (!resetn) begin
      shadow      <= '0;
      ConfigBits  <= '0;
      cfg_update  <= 1'b0;
      err         <= 1'b0;
      frame_ready <= 1'b0;
      idx         <= '0;
`ifdef OUTPASS_CFG_READBACK_EN
      rd_valid    <= 1'b0;
      rd_data     <= '0;
`endif
    end else begin
      frame_ready <= nxt != COMMIT;
      cfg_update  <= do_clear || state == COMMIT;
      err         <= !do_clear && (err || set_err);
      if (state == IDLE && acc) idx <= frame_data[5:0];
      if (do_clear) begin
        shadow     <= '0;
        ConfigBits <= '0;
      end else if (state == COMMIT) ConfigBits <= shadow;
      if (do_wr)
        for (int k = 0; k < NUM_BELS; k++)
          if (idx == 6'(k)) shadow[k*BITS_PER_BEL +: BITS_PER_BEL] <= frame_data[BITS_PER_BEL-1:0];
`ifdef OUTPASS_CFG_READBACK_EN
      rd_valid <= do_rd;
      if (do_rd) rd_data <= sel;
`endif
    end
endmodule

// File: tb/tb_outpass_config_sequencer.sv
// tb_outpass_config_sequencer: directed frames with a queue of expected ConfigBits per cfg_update pulse.
module tb_outpass_config_sequencer;
  logic UserCLK = 1'b0, resetn = 1'b0, frame_valid = 1'b0, frame_last = 1'b0;
  logic [7:0] frame_data = 8'h00;
  logic frame_ready, cfg_update, err;
  logic [15:0] ConfigBits;
  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
`ifdef OUTPASS_CFG_READBACK_EN
  logic rd_valid;
  logic [3:0] rd_data;
`endif
  outpass_config_sequencer #(.NUM_BELS(4), .BITS_PER_BEL(4)) dut (
    .UserCLK(UserCLK), .resetn(resetn), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .frame_last(frame_last), .ConfigBits(ConfigBits),
    .cfg_update(cfg_update), .err(err)
`ifdef OUTPASS_CFG_READBACK_EN
    , .rd_valid(rd_valid), .rd_data(rd_data)
`endif
  );
  always #5 UserCLK = ~UserCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic l, output int waits);
    logic a;
    waits = 0;
    frame_valid = 1'b1;
    frame_data = b;
    frame_last = l;
    do begin
      @(negedge UserCLK);
      a = frame_ready;
      @(posedge UserCLK);
      #1;
      waits++;
    end while (!a && waits < 20);
    frame_valid = 1'b0;
    chk("accept", a, 1);
  endtask
  task automatic s(input logic [7:0] b, input logic l);
    int w;
    send(b, l, w);
  endtask
  task automatic commit(input logic [15:0] e);
    exp_q.push_back(e);
    s(8'h40, 1'b1);
    @(posedge UserCLK);
    #1;
    chk("commit_pulse", cfg_update, 1);
  endtask
  always @(negedge UserCLK)
    if (cfg_update === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_update", cfg_update, 0);
      else chk("update_value", ConfigBits, exp_q.pop_front());
    end
  initial begin
    int w;
    repeat (2) @(posedge UserCLK);
    @(negedge UserCLK);
    chk("rst_ready", frame_ready, 0);
    chk("rst_cfg", ConfigBits, 0);
    chk("rst_err", err, 0);
    chk("rst_update", cfg_update, 0);
`ifdef OUTPASS_CFG_READBACK_EN
    chk("rst_rd_valid", rd_valid, 0);
`endif
    @(posedge UserCLK);
    #1 resetn = 1'b1;
    @(posedge UserCLK);
    #1;
    chk("ready_after_release", frame_ready, 1);
    s(8'h02, 1'b0); s(8'h0A, 1'b1); s(8'h00, 1'b0); s(8'h05, 1'b1);
    chk("shadow_no_disturb", ConfigBits, 0);
    exp_q.push_back(16'h0A05);
    s(8'h40, 1'b1);
    chk("commit_bubble", frame_ready, 0);
    chk("cfg_before_commit", ConfigBits, 0);
    chk("no_early_update", cfg_update, 0);
    @(posedge UserCLK);
    #1;
    chk("commit_update", cfg_update, 1);
    chk("commit_value", ConfigBits, 16'h0A05);
    @(posedge UserCLK);
    #1;
    chk("update_one_cycle", cfg_update, 0);
    s(8'h07, 1'b0); s(8'h0F, 1'b1);
    chk("bad_index_err", err, 1);
    commit(16'h0A05);
    exp_q.push_back(16'h0000);
    s(8'h80, 1'b1);
    chk("clear_err", err, 0);
    chk("clear_cfg", ConfigBits, 0);
    chk("clear_update", cfg_update, 1);
    s(8'h03, 1'b0); s(8'hF6, 1'b1);
    commit(16'h6000);
    s(8'h01, 1'b0);
    resetn = 1'b0;
    @(posedge UserCLK);
    #1 resetn = 1'b1;
    @(posedge UserCLK);
    #1;
    chk("ready_after_midreset", frame_ready, 1);
    chk("midreset_cfg", ConfigBits, 0);
    commit(16'h0000);
    s(8'h00, 1'b0); s(8'h8C, 1'b1);
    chk("data_0x8c_no_clear_err", err, 0);
    exp_q.push_back(16'h000C);
    send(8'h40, 1'b1, w);
    send(8'h01, 1'b0, w);
    chk("held_valid_wait", w, 2);
    s(8'h05, 1'b1);
    commit(16'h005C);
    s(8'h40, 1'b0);
    chk("commit_last0_err", err, 1);
    s(8'h12, 1'b0); s(8'h00, 1'b1);
    s(8'h02, 1'b0); s(8'h03, 1'b1);
    commit(16'h035C);
    chk("err_sticky", err, 1);
    exp_q.push_back(16'h0000);
    s(8'h80, 1'b1);
    chk("clear_err2", err, 0);
    s(8'h01, 1'b1);
    chk("write_last1_err", err, 1);
    exp_q.push_back(16'h0000);
    s(8'h80, 1'b1);
    s(8'h02, 1'b0); s(8'h0A, 1'b1); s(8'h00, 1'b0); s(8'h05, 1'b1);
    commit(16'h0A05);
    s(8'hC2, 1'b1);
`ifdef OUTPASS_CFG_READBACK_EN
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, 4'hA);
    chk("rd_no_err", err, 0);
    @(posedge UserCLK);
    #1;
    chk("rd_valid_pulse", rd_valid, 0);
`else
    chk("reserved_err", err, 1);
`endif
    repeat (3) @(posedge UserCLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
